// File: rtl/rv32i_decoder.sv
// RV32I decode-stage field splitter: slices the instruction word, classifies its format,
// builds the sign-extended immediate, flags illegal encodings, and keeps a one-cycle registered copy.
module rv32i_decoder #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [31:0]     i_instruction,
    output logic [6:0]      o_opcode,
    output logic [4:0]      o_rd,
    output logic [2:0]      o_funct3,
    output logic [4:0]      o_rs1,
    output logic [11:0]     o_immediate,
    output logic [4:0]      o_rs2,
    output logic [6:0]      o_funct7,
    output logic [2:0]      o_fmt,
    output logic [XLEN-1:0] o_imm32,
    output logic            o_illegal,
    output logic            o_q_valid,
    output logic [6:0]      o_q_opcode,
    output logic [4:0]      o_q_rd,
    output logic [2:0]      o_q_funct3,
    output logic [4:0]      o_q_rs1,
    output logic [4:0]      o_q_rs2,
    output logic [6:0]      o_q_funct7,
    output logic [2:0]      o_q_fmt,
    output logic [XLEN-1:0] o_q_imm32,
    output logic            o_q_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_BAD = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [31:0]     instr;
    logic [2:0]      fmt_next;
    logic [XLEN-1:0] imm_next;
    logic            illegal_next;

    assign instr       = i_instruction;
    assign o_opcode    = instr[6:0];
    assign o_rd        = instr[11:7];
    assign o_funct3    = instr[14:12];
    assign o_rs1       = instr[19:15];
    assign o_immediate = instr[31:20];
    assign o_rs2       = instr[24:20];
    assign o_funct7    = instr[31:25];

    always_comb begin
        fmt_next = FMT_BAD;
        case (instr[6:0])
            OPC_OP:                                  fmt_next = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR,
            OPC_SYSTEM, OPC_FENCE:                   fmt_next = FMT_I;
            OPC_STORE:                               fmt_next = FMT_S;
            OPC_BRANCH:                              fmt_next = FMT_B;
            OPC_LUI, OPC_AUIPC:                      fmt_next = FMT_U;
            OPC_JAL:                                 fmt_next = FMT_J;
            default:                                 fmt_next = FMT_BAD;
        endcase
    end

    always_comb begin
        imm_next = '0;
        case (fmt_next)
            FMT_I: imm_next = {{(XLEN-12){instr[31]}}, instr[31:20]};
            FMT_S: imm_next = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm_next = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                               instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm_next = {instr[31:12], 12'b0};
            FMT_J: imm_next = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                               instr[20], instr[30:21], 1'b0};
            default: imm_next = '0;
        endcase
    end

    // Each rule is an independent OR term; an unknown opcode is already covered by FMT_BAD.
    always_comb begin
        illegal_next = (fmt_next == FMT_BAD);
        case (instr[6:0])
            OPC_OP: begin
                if (instr[31:25] != F7_BASE && instr[31:25] != F7_ALT)
                    illegal_next = 1'b1;
                if (instr[31:25] == F7_ALT && instr[14:12] != 3'b000 && instr[14:12] != 3'b101)
                    illegal_next = 1'b1;
            end
            OPC_OP_IMM: begin
                if (instr[14:12] == 3'b001 && instr[31:25] != F7_BASE)
                    illegal_next = 1'b1;
                if (instr[14:12] == 3'b101 && instr[31:25] != F7_BASE && instr[31:25] != F7_ALT)
                    illegal_next = 1'b1;
            end
            OPC_BRANCH: begin
                if (instr[14:12] == 3'b010 || instr[14:12] == 3'b011)
                    illegal_next = 1'b1;
            end
            OPC_LOAD: begin
                if (instr[14:12] == 3'b011 || instr[14:13] == 2'b11)
                    illegal_next = 1'b1;
            end
            OPC_STORE: begin
                if (instr[14:12] >= 3'b011)
                    illegal_next = 1'b1;
            end
            OPC_JALR: begin
                if (instr[14:12] != 3'b000)
                    illegal_next = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_fmt     = fmt_next;
    assign o_imm32   = imm_next;
    assign o_illegal = illegal_next;

    // Fields load every cycle; only the valid bit carries i_valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_q_valid   <= 1'b0;
            o_q_opcode  <= '0;
            o_q_rd      <= '0;
            o_q_funct3  <= '0;
            o_q_rs1     <= '0;
            o_q_rs2     <= '0;
            o_q_funct7  <= '0;
            o_q_fmt     <= '0;
            o_q_imm32   <= '0;
            o_q_illegal <= 1'b0;
        end else begin
            o_q_valid   <= i_valid;
            o_q_opcode  <= instr[6:0];
            o_q_rd      <= instr[11:7];
            o_q_funct3  <= instr[14:12];
            o_q_rs1     <= instr[19:15];
            o_q_rs2     <= instr[24:20];
            o_q_funct7  <= instr[31:25];
            o_q_fmt     <= fmt_next;
            o_q_imm32   <= imm_next;
            o_q_illegal <= illegal_next;
        end
    end

endmodule

// File: tb/tb_rv32i_decoder.sv
// Self-checking bench for rv32i_decoder: directed test-plan vectors plus randomized
// instructions compared against an arithmetic reference model of the RV32I rules.
module tb_rv32i_decoder;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [11:0] immediate;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [2:0]  fmt;
    logic [31:0] imm32;
    logic        illegal;
    logic        q_valid;
    logic [6:0]  q_opcode;
    logic [4:0]  q_rd;
    logic [2:0]  q_funct3;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic [6:0]  q_funct7;
    logic [2:0]  q_fmt;
    logic [31:0] q_imm32;
    logic        q_illegal;

    int n_compared   = 0;
    int n_mismatched = 0;
    int n_txn        = 0;

    rv32i_decoder #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_instruction(instr),
        .o_opcode(opcode), .o_rd(rd), .o_funct3(funct3), .o_rs1(rs1),
        .o_immediate(immediate), .o_rs2(rs2), .o_funct7(funct7),
        .o_fmt(fmt), .o_imm32(imm32), .o_illegal(illegal),
        .o_q_valid(q_valid), .o_q_opcode(q_opcode), .o_q_rd(q_rd),
        .o_q_funct3(q_funct3), .o_q_rs1(q_rs1), .o_q_rs2(q_rs2),
        .o_q_funct7(q_funct7), .o_q_fmt(q_fmt), .o_q_imm32(q_imm32),
        .o_q_illegal(q_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (instr 0x%08h)", tag, got, exp, instr);
        end
    endtask

    function automatic logic [2:0] model_fmt(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op == 7'b0110011) return 3'd0;
        if (op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111}) return 3'd1;
        if (op == 7'b0100011) return 3'd2;
        if (op == 7'b1100011) return 3'd3;
        if (op inside {7'b0110111, 7'b0010111}) return 3'd4;
        if (op == 7'b1101111) return 3'd5;
        return 3'd7;
    endfunction

    // Immediates rebuilt as signed integer sums of weighted bit fields.
    function automatic logic [31:0] model_imm(input logic [31:0] w);
        int a;
        a = 0;
        case (model_fmt(w))
            3'd1: begin
                a = $signed(w[31:20]);
            end
            3'd2: begin
                a = $signed(w[31:25]);
                a = a * 32 + int'(w[11:7]);
            end
            3'd3: begin
                a = w[31] ? -4096 : 0;
                a = a + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            end
            3'd4: a = int'(w & 32'hFFFF_F000);
            3'd5: begin
                a = w[31] ? -1048576 : 0;
                a = a + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            end
            default: a = 0;
        endcase
        return a;
    endfunction

    function automatic logic model_illegal(input logic [31:0] w);
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        return (model_fmt(w) == 3'd7)
            || (op == 7'b0110011 && !(f7 inside {7'h00, 7'h20}))
            || (op == 7'b0110011 && f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}))
            || (op == 7'b0010011 && f3 == 3'd1 && f7 != 7'h00)
            || (op == 7'b0010011 && f3 == 3'd5 && !(f7 inside {7'h00, 7'h20}))
            || (op == 7'b1100011 && f3 inside {3'd2, 3'd3})
            || (op == 7'b0000011 && f3 inside {3'd3, 3'd6, 3'd7})
            || (op == 7'b0100011 && f3 >= 3'd3)
            || (op == 7'b1100111 && f3 != 3'd0);
    endfunction

    // One cycle: drive, check combinational outputs, clock, check registered copy.
    task automatic step(input logic r, input logic v, input logic [31:0] w);
        logic [2:0]  e_fmt;
        logic [31:0] e_imm;
        logic        e_ill;
        rst   = r;
        valid = v;
        instr = w;
        #1;
        e_fmt = model_fmt(w);
        e_imm = model_imm(w);
        e_ill = model_illegal(w);
        check("opcode",    32'(opcode),    32'(w[6:0]));
        check("rd",        32'(rd),        32'(w[11:7]));
        check("funct3",    32'(funct3),    32'(w[14:12]));
        check("rs1",       32'(rs1),       32'(w[19:15]));
        check("immediate", 32'(immediate), 32'(w >> 20));
        check("rs2",       32'(rs2),       32'(w[24:20]));
        check("funct7",    32'(funct7),    32'(w >> 25));
        check("fmt",       32'(fmt),       32'(e_fmt));
        check("imm32",     imm32,          e_imm);
        check("illegal",   32'(illegal),   32'(e_ill));
        @(posedge clk);
        #1;
        check("q_valid",   32'(q_valid),   r ? 32'd0 : 32'(v));
        check("q_opcode",  32'(q_opcode),  r ? 32'd0 : 32'(w[6:0]));
        check("q_rd",      32'(q_rd),      r ? 32'd0 : 32'(w[11:7]));
        check("q_funct3",  32'(q_funct3),  r ? 32'd0 : 32'(w[14:12]));
        check("q_rs1",     32'(q_rs1),     r ? 32'd0 : 32'(w[19:15]));
        check("q_rs2",     32'(q_rs2),     r ? 32'd0 : 32'(w[24:20]));
        check("q_funct7",  32'(q_funct7),  r ? 32'd0 : 32'(w >> 25));
        check("q_fmt",     32'(q_fmt),     r ? 32'd0 : 32'(e_fmt));
        check("q_imm32",   q_imm32,        r ? 32'd0 : e_imm);
        check("q_illegal", 32'(q_illegal), r ? 32'd0 : 32'(e_ill));
        n_txn++;
        $display("txn %0d rst=%0b valid=%0b instr=0x%08h fmt=%0d imm32=0x%08h illegal=%0b",
                 n_txn, r, v, w, e_fmt, e_imm, e_ill);
    endtask

    typedef struct {
        logic [31:0] w;
        logic [2:0]  f;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t plan[6];
    logic [6:0] legal_ops[11];

    initial begin
        plan[0] = '{32'h0000_0013, 3'd1, 32'h0000_0000, 1'b0};
        plan[1] = '{32'h0010_8093, 3'd1, 32'h0000_0001, 1'b0};
        plan[2] = '{32'hFFFF_8113, 3'd1, 32'hFFFF_FFFF, 1'b0};
        plan[3] = '{32'hFE20_AE23, 3'd2, 32'hFFFF_FFFC, 1'b0};
        plan[4] = '{32'h0080_00EF, 3'd5, 32'h0000_0008, 1'b0};
        plan[5] = '{32'h0000_0000, 3'd7, 32'h0000_0000, 1'b1};
        legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
                      7'b0001111, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                      7'b1101111};

        // Reset state: all registered outputs zero.
        rst = 1'b1; valid = 1'b0; instr = '0;
        step(1'b1, 1'b0, 32'h0000_0013);
        step(1'b1, 1'b1, 32'h0010_8093);

        // Test-plan vectors against hand-computed constants, then the model.
        foreach (plan[k]) begin
            rst = 1'b0; valid = 1'b1; instr = plan[k].w;
            #1;
            check("plan_fmt",     32'(fmt),     32'(plan[k].f));
            check("plan_imm32",   imm32,        plan[k].imm);
            check("plan_illegal", 32'(illegal), 32'(plan[k].ill));
            step(1'b0, 1'b1, plan[k].w);
        end
        check("plan_q_imm32_addi", q_imm32, 32'h0000_0000);
        step(1'b0, 1'b1, 32'h0010_8093);
        check("addi_q_valid", 32'(q_valid), 32'd1);
        check("addi_q_imm32", q_imm32, 32'd1);

        // Reset priority over a valid instruction, then resume.
        step(1'b1, 1'b1, 32'h0010_8093);
        check("rst_q_valid", 32'(q_valid), 32'd0);
        step(1'b0, 1'b1, 32'h0010_8093);
        check("resume_q_valid", 32'(q_valid), 32'd1);
        check("resume_q_rd", 32'(q_rd), 32'd1);

        // Randomized instructions biased toward real opcodes and legal funct7 values.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] w;
            int unsigned r;
            w = $urandom;
            r = $urandom_range(0, 9);
            if (r < 8) w[6:0] = legal_ops[$urandom_range(0, 10)];
            r = $urandom_range(0, 3);
            if (r == 0) w[31:25] = 7'h00;
            else if (r == 1) w[31:25] = 7'h20;
            step(($urandom_range(0, 19) == 0), 1'($urandom), w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/rv32i_decoder.md
Name: rv32i_decoder

Overview:
- RV32I instruction field decoder at the decode stage, between instruction fetch and the register file and ALU.
- Splits a 32-bit instruction into opcode, rd, funct3, rs1, rs2, funct7 and the raw I-immediate.
- Classifies the instruction format, builds the sign-extended 32-bit immediate for that format, and flags illegal encodings.
- Provides combinational outputs plus a one-cycle registered copy, qualified by a valid bit.

Parameters:
- XLEN, 32, width of the sign-extended immediate output. Fixed at 32; other values are unsupported.

Ports:
- i_clk  input  1  clock; all registers update on the rising edge.
- i_rst  input  1  synchronous reset, active high.
- i_valid  input  1  i_instruction carries a valid instruction this cycle.
- i_instruction  input  32  instruction word.
- o_opcode  output  7  instr[6:0], combinational.
- o_rd  output  5  instr[11:7], combinational.
- o_funct3  output  3  instr[14:12], combinational.
- o_rs1  output  5  instr[19:15], combinational.
- o_immediate  output  12  instr[31:20], raw and unconditional, combinational.
- o_rs2  output  5  instr[24:20], combinational.
- o_funct7  output  7  instr[31:25], combinational.
- o_fmt  output  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=invalid. Combinational.
- o_imm32  output  32  format-specific sign-extended immediate, combinational.
- o_illegal  output  1  illegal encoding, combinational.
- o_q_valid  output  1  registered i_valid.
- o_q_opcode/o_q_rd/o_q_funct3/o_q_rs1/o_q_rs2/o_q_funct7/o_q_fmt/o_q_imm32/o_q_illegal  output  same widths as above  registered copies of the combinational outputs.

Behaviour:
- Combinational path:
  - Pure bit slicing plus format logic, zero latency.
  - Outputs must be stable within the same delta/cycle as i_instruction.
  - Independent of i_clk, i_rst and i_valid.
- o_immediate is always instr[31:20], whatever the format.
- Format by opcode:
  - R: 0110011
  - I: 0010011, 0000011, 1100111, 1110011, 0001111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - any other opcode: fmt=7
- o_imm32 by format:
  - I: sext(instr[31:20])
  - S: sext({instr[31:25], instr[11:7]})
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - U: {instr[31:12], 12'b0}
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - R or invalid: 0
- o_illegal = 1 when any of:
  - fmt=7 (this includes instr[1:0]!=2'b11).
  - R-type with funct7 not 0000000 or 0100000.
  - R-type with funct7=0100000 and funct3 not 000 or 101.
  - OP-IMM with funct3=001 and funct7!=0000000.
  - OP-IMM with funct3=101 and funct7 not 0000000 or 0100000.
  - Branch with funct3 equal to 010 or 011.
  - Load with funct3 equal to 011, 110 or 111.
  - Store with funct3 >= 011.
  - JALR with funct3!=000.
- Registered path, rising edge of i_clk:
  - i_rst=1: every o_q_* output becomes 0. i_rst has priority over i_valid.
  - Otherwise: o_q_valid <= i_valid, and every o_q_* field loads its combinational value every cycle, regardless of i_valid.
  - Latency: exactly 1 cycle from i_instruction/i_valid to o_q_*.
- Reset mid-stream: the instruction presented in the reset cycle is dropped (o_q_valid=0 on the following cycle). Normal operation resumes on the next non-reset edge.
- No internal state other than the output register stage; back-to-back instructions are accepted every cycle.

Test Plan:
- 0x00000013 (NOP):
  - Combinational: opcode=0010011, rd=0, funct3=000, rs1=0, immediate=0x000, fmt=1, imm32=0, illegal=0.
- 0x00108093 (addi x1,x1,1):
  - Combinational: rd=1, rs1=1, funct3=000, immediate=0x001, imm32=0x00000001.
  - With i_valid=1: o_q_valid=1 and o_q_imm32=1 one cycle later.
- 0xFFFF8113:
  - Combinational: opcode=0010011, rd=2, rs1=31, funct3=000, immediate=0xFFF, imm32=0xFFFFFFFF.
- Store and jump formats:
  - 0xFE20AE23 (sw x2,-4(x1)): fmt=2, rs1=1, rs2=2, funct3=010, imm32=0xFFFFFFFC.
  - 0x008000EF (jal x1,8): fmt=5, rd=1, imm32=0x00000008.
- 0x00000000:
  - fmt=7, illegal=1, imm32=0.
- Reset priority:
  - Pulse i_rst=1 with i_valid=1 and i_instruction=0x00108093 → next cycle all o_q_*=0.
  - Following cycle with i_rst=0 → o_q_valid=1 and o_q_rd=1.
